// File: rtl/adder_rr_scheduler_pkg.sv
// Shared helpers for the adder round-robin scheduler: tag-width derivation
// and the default geometry of the shared adder.
package adder_rr_scheduler_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_REQ    = 4;
    localparam int CLA_GROUP      = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A single requester still needs a one-bit tag on the response port.
    function automatic int id_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping upward. The pointer register lives in the caller.
module rr_arbiter
    import adder_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                en,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] gnt_idx,
    output logic                gnt_vld
);

    int                  idx;
    logic [ID_WIDTH-1:0] idx_w;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx   = (int'(ptr) + i) % NUM_REQ;
            idx_w = ID_WIDTH'(idx);
            if (!gnt_vld && req[idx_w]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_w;
            end
        end
        if (gnt_vld && en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/carry_lookahead_adder.sv
// Combinational adder built from 4-bit lookahead groups; group carries are
// resolved from group generate/propagate so the inter-group path skips bits.
module carry_lookahead_adder
    import adder_rr_scheduler_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGRP = (WIDTH + CLA_GROUP - 1) / CLA_GROUP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NGRP:0]    gc;
    logic             grp_g;
    logic             grp_p;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        gc    = '0;
        gc[0] = cin;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int grp = 0; grp < NGRP; grp++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int j = 0; j < CLA_GROUP; j++) begin
                if (grp * CLA_GROUP + j < WIDTH) begin
                    grp_g = g[grp*CLA_GROUP+j] | (p[grp*CLA_GROUP+j] & grp_g);
                    grp_p = grp_p & p[grp*CLA_GROUP+j];
                end
            end
            gc[grp+1] = grp_g | (grp_p & gc[grp]);
            // Bit carries inside a group only depend on that group's carry-in.
            c[grp*CLA_GROUP] = gc[grp];
            for (int j = 0; j < CLA_GROUP - 1; j++) begin
                if (grp * CLA_GROUP + j + 1 < WIDTH) begin
                    c[grp*CLA_GROUP+j+1] = g[grp*CLA_GROUP+j]
                                         | (p[grp*CLA_GROUP+j] & c[grp*CLA_GROUP+j]);
                end
            end
        end
        sum  = p ^ c;
        cout = gc[NGRP];
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one carry-lookahead adder between NUM_REQ requesters through a
// round-robin arbiter and a 2-stage operand/result pipeline with backpressure.
module adder_rr_scheduler
    import adder_rr_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            iv_req_valid,
    output logic [NUM_REQ-1:0]            ov_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] iv_req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] iv_req_b,
    input  logic [NUM_REQ-1:0]            iv_req_cin,
    output logic                          ov_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [ID_WIDTH-1:0]           ov_rsp_id,
    output logic [DATA_WIDTH-1:0]         ov_rsp_sum,
    output logic                          ov_rsp_cout,
    output logic                          ov_busy
);

    logic [DATA_WIDTH-1:0] req_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_b [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_a[k] = iv_req_a[k*DATA_WIDTH +: DATA_WIDTH];
        assign req_b[k] = iv_req_b[k*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   rr_ptr_nxt;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic                  gnt_vld;
    logic [NUM_REQ-1:0]    gnt;
    logic                  s1_en;
    logic                  s2_en;
    logic                  arb_en;
    logic                  xfer;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] a_p1;
    logic [DATA_WIDTH-1:0] b_p1;
    logic                  cin_p1;
    logic [ID_WIDTH-1:0]   id_p1;

    logic                  vld_p2;
    logic [DATA_WIDTH-1:0] sum_p2;
    logic                  cout_p2;
    logic [ID_WIDTH-1:0]   id_p2;

    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_cout;

    assign s2_en  = !vld_p2 | i_rsp_ready;
    assign s1_en  = !vld_p1 | s2_en;
    // Keep ready low while reset is held, even though s1_en is already 1.
    assign arb_en = s1_en & i_rst_n;
    assign xfer   = gnt_vld & arb_en;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req     (iv_req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign ov_req_ready = gnt;
    assign rr_ptr_nxt   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_WIDTH'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Stage 1: operand capture from the granted requester
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            cin_p1 <= 1'b0;
            id_p1  <= '0;
        end else if (s1_en) begin
            vld_p1 <= xfer;
            a_p1   <= req_a[gnt_idx];
            b_p1   <= req_b[gnt_idx];
            cin_p1 <= iv_req_cin[gnt_idx];
            id_p1  <= gnt_idx;
        end
    end

    carry_lookahead_adder #(
        .WIDTH (DATA_WIDTH)
    ) u_cla (
        .a    (a_p1),
        .b    (b_p1),
        .cin  (cin_p1),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Stage 2: result capture, drives the response port directly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p2  <= 1'b0;
            sum_p2  <= '0;
            cout_p2 <= 1'b0;
            id_p2   <= '0;
        end else if (s2_en) begin
            vld_p2  <= vld_p1;
            sum_p2  <= add_sum;
            cout_p2 <= add_cout;
            id_p2   <= id_p1;
        end
    end

    assign ov_rsp_valid = vld_p2;
    assign ov_rsp_id    = id_p2;
    assign ov_rsp_sum   = sum_p2;
    assign ov_rsp_cout  = cout_p2;
    assign ov_busy      = vld_p1 | vld_p2;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: latency, overflow, fairness,
// backpressure, sparse round-robin and asynchronous reset mid-flight.
module tb_adder_rr_scheduler;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic [NR-1:0]     req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_sum;
    logic              rsp_cout;
    logic              busy;

    int total;
    int bad;

    adder_rr_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .iv_req_valid (req_valid),
        .ov_req_ready (req_ready),
        .iv_req_a     (req_a),
        .iv_req_b     (req_b),
        .iv_req_cin   (req_cin),
        .ov_rsp_valid (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .ov_rsp_id    (rsp_id),
        .ov_rsp_sum   (rsp_sum),
        .ov_rsp_cout  (rsp_cout),
        .ov_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic cin);
        req_a[k*DW +: DW] = a;
        req_b[k*DW +: DW] = b;
        req_cin[k]        = cin;
    endtask

    // One isolated transaction with i_rsp_ready held high.
    task automatic issue_one(input string tag, input int k, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic cin,
                             input logic [DW-1:0] exp_sum, input logic exp_cout);
        set_ops(k, a, b, cin);
        req_valid = NR'(1) << k;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(NR'(1) << k));
        tick();
        req_valid = '0;
        chk({tag, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_lat1_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(k));
        chk({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
        tick();
        chk({tag, "_drained"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic fair_ops();
        for (int k = 0; k < NR; k++) begin
            set_ops(k, DW'(k << 12), DW'(k), 1'b0);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests asserted to confirm ready stays low
        #3;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        #9;
        req_valid = '0;
        rst_n     = 1'b1;
        tick();

        issue_one("single", 2, 16'h1234, 16'h0FF0, 1'b1, 16'h2225, 1'b0);
        issue_one("ovf1", 0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        issue_one("ovf2", 1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);

        // Fairness from a freshly reset pointer
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        fair_ops();
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? '1 : '0;
            #1;
            if (c < 8) begin
                chk("fair_ready", 32'(req_ready), 32'(NR'(1) << (c % NR)));
            end
            if (c >= 2) begin
                chk("fair_valid", 32'(rsp_valid), 32'd1);
                chk("fair_id", 32'(rsp_id), 32'((c - 2) % NR));
                chk("fair_sum", 32'(rsp_sum), 32'((((c - 2) % NR) << 12) + ((c - 2) % NR)));
            end else begin
                chk("fair_warm_valid", 32'(rsp_valid), 32'd0);
            end
            tick();
        end
        req_valid = '0;
        chk("fair_idle_busy", 32'(busy), 32'd0);

        // Backpressure: two accepts fill the pipeline, then ready drops
        rsp_ready = 1'b0;
        req_valid = '1;
        #1;
        chk("bp_ready0", 32'(req_ready), 32'h1);
        tick();
        chk("bp_ready1", 32'(req_ready), 32'h2);
        chk("bp_valid1", 32'(rsp_valid), 32'd0);
        tick();
        chk("bp_full_ready", 32'(req_ready), 32'h0);
        chk("bp_full_valid", 32'(rsp_valid), 32'd1);
        chk("bp_full_id", 32'(rsp_id), 32'd0);
        chk("bp_full_sum", 32'(rsp_sum), 32'h0000);
        tick();
        chk("bp_hold_ready", 32'(req_ready), 32'h0);
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        chk("bp_hold_id", 32'(rsp_id), 32'd0);
        chk("bp_hold_sum", 32'(rsp_sum), 32'h0000);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_drain_valid", 32'(rsp_valid), 32'd1);
        chk("bp_drain_id", 32'(rsp_id), 32'd1);
        chk("bp_drain_sum", 32'(rsp_sum), 32'h1001);
        tick();
        chk("bp_empty_valid", 32'(rsp_valid), 32'd0);
        chk("bp_empty_busy", 32'(busy), 32'd0);

        // Sparse round-robin: move pointer to 1, then only 0 and 3 request
        issue_one("sp_prep", 0, 16'h0100, 16'h0020, 1'b0, 16'h0120, 1'b0);
        fair_ops();
        req_valid = 4'b1001;
        #1;
        chk("sp_ready_first", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("sp_ready_second", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("sp_rsp1_id", 32'(rsp_id), 32'd3);
        chk("sp_rsp1_sum", 32'(rsp_sum), 32'h3003);
        tick();
        chk("sp_rsp2_valid", 32'(rsp_valid), 32'd1);
        chk("sp_rsp2_id", 32'(rsp_id), 32'd0);
        tick();
        chk("sp_done_valid", 32'(rsp_valid), 32'd0);

        // Reset mid-flight with two transactions in the pipeline
        req_valid = 4'b0011;
        #1;
        chk("rmf_ready0", 32'(req_ready), 32'h2);
        tick();
        chk("rmf_ready1", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("rmf_pre_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmf_rst_valid", 32'(rsp_valid), 32'd0);
        chk("rmf_rst_busy", 32'(busy), 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rmf_post_valid", 32'(rsp_valid), 32'd0);
            chk("rmf_post_busy", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one carry_lookahead_adder datapath between NUM_REQ requesters.
- Each requester presents an operand pair through a valid/ready handshake.
- A round-robin arbiter selects one request per cycle and issues it into a 2-stage operand/result pipeline wrapped around the combinational adder.
- Results return on a single tagged response port with backpressure; the block sits between the requesting engines and the shared adder.

Parameters:
- DATA_WIDTH, 16, operand and sum width.
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, clog2(NUM_REQ) (min 1), width of the requester tag.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- iv_req_valid  in  NUM_REQ  per-requester request valid.
- ov_req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- iv_req_a  in  NUM_REQ*DATA_WIDTH  operand A, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- iv_req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing.
- iv_req_cin  in  NUM_REQ  carry-in per requester.
- ov_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  downstream accepts response.
- ov_rsp_id  out  ID_WIDTH  index of originating requester.
- ov_rsp_sum  out  DATA_WIDTH  sum.
- ov_rsp_cout  out  1  carry-out.
- ov_busy  out  1  any pipeline stage occupied.

Behaviour:
- Reset:
  - On i_rst_n low, asynchronously clear: s1_valid, s2_valid, the round-robin pointer (to 0), and all stage data and tag registers (to 0).
  - Outputs in reset: ov_rsp_valid=0, ov_rsp_id=0, ov_rsp_sum=0, ov_rsp_cout=0, ov_busy=0, ov_req_ready=0.
  - Reset mid-operation discards in-flight transactions with no response.
- Pipeline enables:
  - s2_en = !s2_valid | i_rsp_ready.
  - s1_en = !s1_valid | s2_en.
- Arbitration (combinational):
  - Among the asserted iv_req_valid bits, grant the first index at or after the pointer, searching upward with wrap-around.
  - ov_req_ready[g] = s1_en & iv_req_valid[g]. All other bits are 0.
  - No grant is made when no request is valid.
- Handshake:
  - A transfer occurs when iv_req_valid[g] & ov_req_ready[g].
  - On a transfer, the pointer becomes (g+1) mod NUM_REQ. Otherwise the pointer holds.
  - Requesters must hold valid and operands stable until ready.
  - Dropping valid without a transfer is permitted and loses no state.
- Stage 1 (when s1_en):
  - Load a, b, cin, id from the granted requester.
  - s1_valid <= transfer occurred.
- Stage 2 (when s2_en):
  - Load sum and cout from carry_lookahead_adder(s1 a, b, cin), plus the s1 id.
  - s2_valid <= s1_valid.
- Response port:
  - ov_rsp_* are driven directly from stage-2 registers.
  - When ov_rsp_valid=1 and i_rsp_ready=0, all response outputs hold unchanged.
- Latency and throughput:
  - Handshake in cycle t gives ov_rsp_valid=1 in cycle t+2 (after two edges) if unstalled.
  - Throughput is 1 result/cycle with i_rsp_ready held high.
- Backpressure:
  - A full pipeline (both stages valid) with i_rsp_ready=0 drives all ov_req_ready to 0.
  - One cycle of i_rsp_ready=1 frees one slot, so the next cycle may accept again.
  - No transaction is ever dropped or duplicated.
- Simultaneous events: a response pop and a request accept in the same cycle are both legal and both take effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(DATA_WIDTH+1). Wrap-around is via cout only; there is no saturation.
- Ordering: responses emerge in grant order.
- Busy flag: ov_busy = s1_valid | s2_valid.
- Fairness: with all requesters continuously valid and no stall, grants cycle 0,1,...,NUM_REQ-1,0,... Any continuously-valid requester waits at most NUM_REQ-1 grants.

Decomposition:
- Shared package/header:
  - clog2 function.
  - ID_WIDTH derivation.
  - Operand slice macro/function for packed request buses.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; the pointer register stays in the top.
- The existing carry_lookahead_adder is instantiated unregistered between stage 1 and stage 2.

Test Plan:
- Single request: requester 2 sends a=0x1234, b=0x0FF0, cin=1 with i_rsp_ready=1. Response 2 cycles after the handshake: id=2, sum=0x2225, cout=0.
- Overflow: a=0xFFFF, b=0x0001, cin=0. Required: sum=0x0000, cout=1. Repeat with a=0xFFFF, b=0xFFFF, cin=1: sum=0xFFFF, cout=1.
- Fairness: all 4 requesters valid for 8 cycles with pointer reset to 0. Grant/response id sequence must be 0,1,2,3,0,1,2,3, one response per cycle from cycle 2.
- Backpressure: i_rsp_ready=0 with requests pending. Exactly 2 handshakes occur, then all ov_req_ready=0 and response outputs hold. Release i_rsp_ready: the 2 results drain in order and no id is skipped or repeated.
- Sparse round-robin: pointer at 1, only requesters 0 and 3 valid. Grant order must be 3 then 0. A requester dropping valid mid-wait is never granted.
- Reset mid-flight: assert i_rsp_ready=1, issue 2 requests, pull i_rst_n low between clock edges. Required: ov_rsp_valid and ov_busy go 0 immediately, and no stale response appears after reset release.
